// File: rtl/jelly3_instruction_fetch_delay_pipe_if.sv
// rtl/jelly3_instruction_fetch_delay_pipe_if.sv - fetch token stream (id, pc, mem) with valid/ready handshake
interface jelly3_instruction_fetch_delay_pipe_if #(
    parameter int ID_BITS = 2,
    parameter int PC_BITS = 32
);
    logic [ID_BITS-1:0] id;
    logic [PC_BITS-1:0] pc;
    logic               mem;
    logic               valid;
    logic               ready;

    modport master (output id, pc, mem, valid, input  ready);
    modport slave  (input  id, pc, mem, valid, output ready);
endinterface

// File: rtl/jelly3_instruction_fetch_delay_pipe.sv
// rtl/jelly3_instruction_fetch_delay_pipe.sv - LATENCY-stage fetch token delay line with bubble collapse and per-thread squash
module jelly3_instruction_fetch_delay_pipe #(
    parameter int  ID_BITS  = 2,
    parameter type id_t     = logic [ID_BITS-1:0],
    parameter int  PC_BITS  = 32,
    parameter type pc_t     = logic [PC_BITS-1:0],
    parameter int  LATENCY  = 2,
    parameter int  CNT_BITS = $clog2(LATENCY+1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cke,
    input  logic                branch_en,
    input  id_t                 branch_id,
    input  pc_t                 branch_pc,
    jelly3_instruction_fetch_delay_pipe_if.slave  s,
    jelly3_instruction_fetch_delay_pipe_if.master m,
    output logic [CNT_BITS-1:0] occupancy
);

    id_t                id_q [LATENCY];
    id_t                id_d [LATENCY];
    pc_t                pc_q [LATENCY];
    pc_t                pc_d [LATENCY];
    logic [LATENCY-1:0] mem_q, mem_d;
    logic [LATENCY-1:0] valid_q, valid_d;
    logic [LATENCY:0]   rdy;
    logic               chain;
    logic               unused_branch_pc;

    assign unused_branch_pc = ^branch_pc;

    // A stage can accept when it is empty or everything downstream can move;
    // accumulated through a temporary so the chain has no self-referencing vector.
    always_comb begin
        chain        = m.ready;
        rdy[LATENCY] = m.ready;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            chain  = chain || !valid_q[k];
            rdy[k] = chain;
        end
    end

    assign s.ready = cke && rdy[0];

    always_comb begin
        for (int k = 0; k < LATENCY; k++) begin
            id_d[k] = id_q[k];
            pc_d[k] = pc_q[k];
        end
        mem_d   = mem_q;
        valid_d = valid_q;
        if (cke) begin
            if (rdy[0]) begin
                id_d[0]    = s.id;
                pc_d[0]    = s.pc;
                mem_d[0]   = s.mem;
                valid_d[0] = s.valid;
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (rdy[k]) begin
                    id_d[k]    = id_q[k-1];
                    pc_d[k]    = pc_q[k-1];
                    mem_d[k]   = mem_q[k-1];
                    valid_d[k] = valid_q[k-1];
                end
            end
            // Squash looks at the token landing in each stage, so a token handed
            // off at the output this edge is already gone and unaffected.
            for (int k = 0; k < LATENCY; k++) begin
                if (branch_en && (id_d[k] == branch_id)) begin
                    valid_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                id_q[k] <= '0;
                pc_q[k] <= '0;
            end
            mem_q   <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                id_q[k] <= id_d[k];
                pc_q[k] <= pc_d[k];
            end
            mem_q   <= mem_d;
            valid_q <= valid_d;
        end
    end

    assign m.id    = id_q[LATENCY-1];
    assign m.pc    = pc_q[LATENCY-1];
    assign m.mem   = mem_q[LATENCY-1];
    assign m.valid = valid_q[LATENCY-1];

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < LATENCY; k++) begin
            occupancy = occupancy + CNT_BITS'(valid_q[k]);
        end
    end

endmodule

// File: tb/tb_jelly3_instruction_fetch_delay_pipe.sv
// tb/tb_jelly3_instruction_fetch_delay_pipe.sv - table-driven bench for the fetch delay pipe at LATENCY=3
module tb_jelly3_instruction_fetch_delay_pipe;

    logic        clk;
    logic        reset;
    logic        cke;
    logic        branch_en;
    logic [1:0]  branch_id;
    logic [31:0] branch_pc;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    jelly3_instruction_fetch_delay_pipe_if #(.ID_BITS(2), .PC_BITS(32)) s_if ();
    jelly3_instruction_fetch_delay_pipe_if #(.ID_BITS(2), .PC_BITS(32)) m_if ();

    jelly3_instruction_fetch_delay_pipe #(
        .ID_BITS (2),
        .PC_BITS (32),
        .LATENCY (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cke       (cke),
        .branch_en (branch_en),
        .branch_id (branch_id),
        .branch_pc (branch_pc),
        .s         (s_if),
        .m         (m_if),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cke;
        logic        sv;
        logic [1:0]  sid;
        logic [31:0] spc;
        logic        mr;
        logic        be;
        logic [1:0]  bid;
        logic        xs;
        logic        xmv;
        logic [1:0]  xid;
        logic [31:0] xpc;
        logic        xmem;
        logic [1:0]  xocc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic c, input logic sv, input logic [1:0] sid, input logic [31:0] spc,
                               input logic mr, input logic be, input logic [1:0] bid,
                               input logic xs, input logic xmv, input logic [1:0] xid,
                               input logic [31:0] xpc, input logic xmem, input logic [1:0] xocc);
        vec_t r;
        r.cke = c;  r.sv = sv;  r.sid = sid; r.spc = spc; r.mr = mr; r.be = be; r.bid = bid;
        r.xs = xs;  r.xmv = xmv; r.xid = xid; r.xpc = xpc; r.xmem = xmem; r.xocc = xocc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t r, input int idx);
        cke        = r.cke;
        s_if.valid = r.sv;
        s_if.id    = r.sid;
        s_if.pc    = r.spc;
        s_if.mem   = r.sid[0];
        m_if.ready = r.mr;
        branch_en  = r.be;
        branch_id  = r.bid;
        #1;
        chk($sformatf("row%0d s_ready", idx), 32'(s_if.ready), 32'(r.xs));
        @(posedge clk);
        #1;
        chk($sformatf("row%0d m_valid", idx), 32'(m_if.valid), 32'(r.xmv));
        chk($sformatf("row%0d occupancy", idx), 32'(occupancy), 32'(r.xocc));
        if (r.xmv) begin
            chk($sformatf("row%0d m_id", idx), 32'(m_if.id), 32'(r.xid));
            chk($sformatf("row%0d m_pc", idx), m_if.pc, r.xpc);
            chk($sformatf("row%0d m_mem", idx), 32'(m_if.mem), 32'(r.xmem));
        end
    endtask

    initial begin
        // stream, m_ready held high
        vt.push_back(v(1,1,0,32'h100,1,0,0, 1,0,0,0,0,1));
        vt.push_back(v(1,1,1,32'h104,1,0,0, 1,0,0,0,0,2));
        vt.push_back(v(1,1,2,32'h108,1,0,0, 1,1,0,32'h100,0,3));
        vt.push_back(v(1,1,3,32'h10C,1,0,0, 1,1,1,32'h104,1,3));
        vt.push_back(v(1,0,0,0,1,0,0,       1,1,2,32'h108,0,2));
        vt.push_back(v(1,0,0,0,1,0,0,       1,1,3,32'h10C,1,1));
        vt.push_back(v(1,0,0,0,1,0,0,       1,0,0,0,0,0));
        // backpressure fill, then release
        vt.push_back(v(1,1,0,32'h200,0,0,0, 1,0,0,0,0,1));
        vt.push_back(v(1,1,1,32'h204,0,0,0, 1,0,0,0,0,2));
        vt.push_back(v(1,1,2,32'h208,0,0,0, 1,1,0,32'h200,0,3));
        vt.push_back(v(1,1,3,32'h20C,0,0,0, 0,1,0,32'h200,0,3));
        vt.push_back(v(1,1,0,32'h210,0,0,0, 0,1,0,32'h200,0,3));
        vt.push_back(v(1,0,0,0,1,0,0,       1,1,1,32'h204,1,2));
        vt.push_back(v(1,0,0,0,1,0,0,       1,1,2,32'h208,0,1));
        vt.push_back(v(1,0,0,0,1,0,0,       1,0,0,0,0,0));
        // bubble collapse
        vt.push_back(v(1,1,1,32'h300,1,0,0, 1,0,0,0,0,1));
        vt.push_back(v(1,0,0,0,0,0,0,       1,0,0,0,0,1));
        vt.push_back(v(1,1,2,32'h304,0,0,0, 1,1,1,32'h300,1,2));
        vt.push_back(v(1,0,0,0,0,0,0,       1,1,1,32'h300,1,2));
        vt.push_back(v(1,0,0,0,1,0,0,       1,1,2,32'h304,0,1));
        vt.push_back(v(1,0,0,0,1,0,0,       1,0,0,0,0,0));
        // squash id 1 with input and output handoff in the same cycle
        vt.push_back(v(1,1,1,32'h400,0,0,0, 1,0,0,0,0,1));
        vt.push_back(v(1,1,2,32'h404,0,0,0, 1,0,0,0,0,2));
        vt.push_back(v(1,1,1,32'h408,0,0,0, 1,1,1,32'h400,1,3));
        vt.push_back(v(1,1,1,32'h40C,1,1,1, 1,1,2,32'h404,0,1));
        vt.push_back(v(1,0,0,0,1,0,0,       1,0,0,0,0,0));
        // cke gating with branch pulses
        vt.push_back(v(1,1,0,32'h500,1,0,0, 1,0,0,0,0,1));
        vt.push_back(v(1,1,1,32'h504,1,0,0, 1,0,0,0,0,2));
        vt.push_back(v(0,1,2,32'h508,1,1,0, 0,0,0,0,0,2));
        vt.push_back(v(0,1,2,32'h508,1,1,1, 0,0,0,0,0,2));
        vt.push_back(v(0,1,2,32'h508,1,0,0, 0,0,0,0,0,2));
        vt.push_back(v(0,1,2,32'h508,1,1,0, 0,0,0,0,0,2));
        vt.push_back(v(1,1,2,32'h508,1,0,0, 1,1,0,32'h500,0,3));
        vt.push_back(v(1,0,0,0,1,0,0,       1,1,1,32'h504,1,2));
        vt.push_back(v(1,0,0,0,1,0,0,       1,1,2,32'h508,0,1));
        vt.push_back(v(1,0,0,0,1,0,0,       1,0,0,0,0,0));

        reset      = 1'b1;
        cke        = 1'b0;
        branch_en  = 1'b0;
        branch_id  = '0;
        branch_pc  = 32'h0;
        s_if.valid = 1'b0;
        s_if.id    = '0;
        s_if.pc    = '0;
        s_if.mem   = 1'b0;
        m_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset s_ready cke0", 32'(s_if.ready), 32'd0);
        cke = 1'b1;
        #1;
        chk("reset s_ready cke1", 32'(s_if.ready), 32'd1);
        chk("reset m_valid", 32'(m_if.valid), 32'd0);
        chk("reset occupancy", 32'(occupancy), 32'd0);
        chk("reset m_mem", 32'(m_if.mem), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i], i);
        end

        // reset with three valid stages drops everything
        for (int i = 0; i < 3; i++) begin
            s_if.valid = 1'b1;
            s_if.id    = 2'(3 - i);
            s_if.pc    = 32'h600 + 32'(4 * i);
            s_if.mem   = 1'b1;
            m_if.ready = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("prereset occupancy", 32'(occupancy), 32'd3);
        reset      = 1'b1;
        m_if.ready = 1'b1;
        s_if.id    = 2'd0;
        @(posedge clk);
        #1;
        chk("midreset m_valid", 32'(m_if.valid), 32'd0);
        chk("midreset occupancy", 32'(occupancy), 32'd0);
        chk("midreset m_mem", 32'(m_if.mem), 32'd0);
        reset      = 1'b0;
        s_if.valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postreset m_valid %0d", i), 32'(m_if.valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
